multicycle_controller: RTL and testbench

Multicycle control FSM for the MIPS core. It sequences one instruction at a time through the shared ALU, register file and single memory port: fetch, decode, execute, memory and writeback. It replaces per-instruction static control with per-cycle strobes and handles variable-latency memory through a ready handshake with a timeout. It sits between the instruction register (opcode/funct in), the ALU zero flag, the memory port and the datapath muxes.

---
 rtl/mips_ctrl_pkg.sv | 66 ++++++
 rtl/multicycle_controller_timer.sv | 28 ++
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes, ALU operand/op selects and the per-cycle strobe bundle.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Opcode/funct combinations the datapath can execute.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR};
            OP_ADDI, OP_ORI, OP_LUI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_timer.sv
// Memory wait timer: counts unready FETCH/MEM cycles and flags a timeout on
// the cycle that would exhaust the MEM_TIMEOUT budget.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wait_cnt <= '0;
        end else if (tick) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout = tick && (wait_cnt == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/exec/mem/writeback and
// issues per-cycle datapath strobes, with a timed memory ready handshake.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        instr_done,
    output logic        illegal,
    output logic        error,
    output logic [31:0] retired,
    output logic [2:0]  state
);

    import mips_ctrl_pkg::*;

    localparam int unsigned RET_W = 32;

    state_t state_q;
    state_t state_d;
    state_t after_done;
    ctrl_t  ctrl;

    logic is_r, is_br, is_lw, is_sw, is_logic, taken;
    logic timeout, wait_clear, wait_tick;

    assign is_r     = (opcode == OP_RTYPE);
    assign is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_logic = (opcode == OP_ORI) || (opcode == OP_LUI);
    assign taken    = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

    // run is only consulted when an instruction retires (and in IDLE)
    assign after_done = run ? ST_FETCH : ST_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_BRANCH;
                ctrl.alu_op    = ALU_ADD;
                if (is_legal(opcode, funct)) begin
                    state_d = ST_EXEC;
                end else begin
                    ctrl.illegal    = 1'b1;
                    ctrl.instr_done = 1'b1;
                    state_d         = after_done;
                end
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = (is_r || is_br) ? SRCB_RT : SRCB_IMM;
                if (is_r)          ctrl.alu_op = ALU_FUNCT;
                else if (is_br)    ctrl.alu_op = ALU_SUB;
                else if (is_logic) ctrl.alu_op = ALU_LOGIC;
                else               ctrl.alu_op = ALU_ADD;
                if (is_br) begin
                    ctrl.pc_write   = taken;
                    ctrl.pc_src     = taken;
                    ctrl.instr_done = 1'b1;
                    state_d         = after_done;
                end else if (is_lw || is_sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_read  = is_lw;
                ctrl.mem_write = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        ctrl.instr_done = 1'b1;
                        state_d         = after_done;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = is_r;
                ctrl.mem_to_reg = is_lw;
                ctrl.instr_done = 1'b1;
                state_d         = after_done;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // a reset in flight aborts the instruction with no further strobes
        if (rst) ctrl = '0;
    end

    assign wait_tick  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
    assign wait_clear = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (wait_clear),
        .tick   (wait_tick),
        .timeout(timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
            error   <= 1'b0;
        end else begin
            if (ctrl.instr_done) retired <= retired + RET_W'(1);
            if (state_d == ST_ERR) error <= 1'b1;
        end
    end

    assign pc_write   = ctrl.pc_write;
    assign pc_src     = ctrl.pc_src;
    assign ir_write   = ctrl.ir_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign iord       = ctrl.iord;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign instr_done = ctrl.instr_done;
    assign illegal    = ctrl.illegal;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle state/strobe checks
// plus a scoreboard of expected latency and retire count per instruction.
module tb_multicycle_controller;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst, run, zero, mem_ready;
    logic [5:0]  opcode, funct;
    logic        pc_write, pc_src, ir_write, mem_read, mem_write, iord, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        reg_write, reg_dst, mem_to_reg, instr_done, illegal, error;
    logic [31:0] retired;
    logic [2:0]  state;
    logic [15:0] strobes;

    multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal(illegal),
        .error(error), .retired(retired), .state(state)
    );

    assign strobes = {pc_write, pc_src, ir_write, mem_read, mem_write, iord, alu_src_a,
                      alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, instr_done, illegal};

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int   lat;
        logic ill;
        int   ret;
    } exp_t;

    exp_t sb[$];
    int   exp_retired = 0;

    // Monitor: cycles since FETCH entry, compared on every instr_done.
    int         cyc = 0;
    logic [2:0] prev_state = 3'd0;
    always @(negedge clk) begin
        exp_t e;
        if (state == 3'd1 && prev_state != 3'd1) cyc = 1;
        else if (cyc != 0) cyc++;
        prev_state = state;
        if (instr_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(instr_done), 32'(0));
            end else begin
                e = sb.pop_front();
                check("latency", 32'(cyc), 32'(e.lat));
                check("illegal_at_done", 32'(illegal), 32'(e.ill));
                check("retired_before_done", retired, 32'(e.ret));
            end
        end
    end

    function automatic logic tb_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25);
        return (op == 6'h08) || (op == 6'h0D) || (op == 6'h0F) || (op == 6'h23) ||
               (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
    endfunction

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 after retirement.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw, input logic keep_run);
        logic legal, is_r, is_br, is_lw, is_sw, taken;
        logic [1:0] eop, esb;
        int lat;
        legal = tb_legal(op, fn);
        is_r  = (op == 6'h00);
        is_br = (op == 6'h04) || (op == 6'h05);
        is_lw = (op == 6'h23);
        is_sw = (op == 6'h2B);
        taken = ((op == 6'h04) && z) || ((op == 6'h05) && !z);
        eop   = is_r ? 2'b10 : is_br ? 2'b01 : ((op == 6'h0D) || (op == 6'h0F)) ? 2'b11 : 2'b00;
        esb   = (is_r || is_br) ? 2'b00 : 2'b10;
        if (!legal)              lat = 2 + fw;
        else if (is_br)          lat = 3 + fw;
        else if (is_lw)          lat = 5 + fw + mw;
        else if (is_sw)          lat = 4 + fw + mw;
        else                     lat = 4 + fw;
        sb.push_back('{lat: lat, ill: !legal, ret: exp_retired});
        exp_retired++;
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int i = 0; i <= fw; i++) begin
            mem_ready = (i == fw);
            #1;
            check("fetch_state", 32'(state), 32'(1));
            check("fetch_strobes", 32'({mem_read, iord, alu_src_a, alu_src_b, alu_op, ir_write, pc_write}),
                  32'({1'b1, 1'b0, 1'b0, 2'b01, 2'b00, mem_ready, mem_ready}));
            @(posedge clk); #1;
        end
        if (!keep_run) run = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("decode_state", 32'(state), 32'(2));
        check("decode_strobes", 32'({alu_src_a, alu_src_b, alu_op, illegal, instr_done, reg_write, mem_write, mem_read}),
              32'({1'b0, 2'b11, 2'b00, !legal, !legal, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); #1;
        if (legal) begin
            #1;
            check("exec_state", 32'(state), 32'(3));
            check("exec_strobes", 32'({alu_src_a, alu_src_b, alu_op, pc_write, pc_src, instr_done, mem_read, mem_write}),
                  32'({1'b1, esb, eop, taken, taken, is_br, 1'b0, 1'b0}));
            @(posedge clk); #1;
            if (is_lw || is_sw) begin
                for (int i = 0; i <= mw; i++) begin
                    mem_ready = (i == mw);
                    #1;
                    check("mem_state", 32'(state), 32'(4));
                    check("mem_strobes", 32'({iord, mem_read, mem_write, instr_done, reg_write}),
                          32'({1'b1, is_lw, is_sw, is_sw && mem_ready, 1'b0}));
                    @(posedge clk); #1;
                end
                mem_ready = 1'b1;
            end
            if (!is_br && !is_sw) begin
                #1;
                check("wb_state", 32'(state), 32'(5));
                check("wb_strobes", 32'({reg_write, reg_dst, mem_to_reg, instr_done, mem_write}),
                      32'({1'b1, is_r, is_lw, 1'b1, 1'b0}));
                @(posedge clk); #1;
            end
        end
        check("after_done_state", 32'(state), keep_run ? 32'(1) : 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        opcode = 6'h00; funct = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'(0));
        check("reset_retired", retired, 32'(0));
        check("reset_error", 32'(error), 32'(0));
        check("reset_strobes", 32'(strobes), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_hold", 32'(state), 32'(0));
        run = 1'b1;
        @(posedge clk); #1;

        do_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b1);  // add
        do_instr(6'h00, 6'h22, 1'b0, 1, 0, 1'b1);  // sub, one fetch wait
        do_instr(6'h08, 6'h00, 1'b0, 0, 0, 1'b1);  // addi
        do_instr(6'h0D, 6'h00, 1'b0, 0, 0, 1'b1);  // ori
        do_instr(6'h0F, 6'h00, 1'b0, 0, 0, 1'b1);  // lui
        do_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b1);  // lw, three mem waits
        do_instr(6'h2B, 6'h00, 1'b0, 0, 1, 1'b1);  // sw, one mem wait
        do_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b1);  // beq taken
        do_instr(6'h05, 6'h00, 1'b1, 0, 0, 1'b1);  // bne not taken
        do_instr(6'h05, 6'h00, 1'b0, 0, 0, 1'b1);  // bne taken
        do_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b1);  // beq not taken
        do_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b1);  // illegal opcode
        do_instr(6'h00, 6'h2A, 1'b0, 0, 0, 1'b1);  // illegal funct
        do_instr(6'h00, 6'h24, 1'b0, 0, 0, 1'b1);  // and
        do_instr(6'h08, 6'h00, 1'b0, TMO - 1, 0, 1'b1);  // ready on last allowed cycle
        do_instr(6'h23, 6'h00, 1'b0, 0, TMO - 1, 1'b1);
        check("no_error_at_limit", 32'(error), 32'(0));
        do_instr(6'h00, 6'h25, 1'b0, 0, 0, 1'b0);  // or, run dropped mid-instruction
        check("retired_total", retired, 32'(exp_retired));
        @(posedge clk); #1;
        check("idle_stays", 32'(state), 32'(0));

        // Reset during MEM of a store
        run = 1'b1; opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("abort_mem_state", 32'(state), 32'(4));
        check("abort_mem_write", 32'(mem_write), 32'(1));
        rst = 1'b1;
        #1;
        check("rst_gates_strobes", 32'(strobes), 32'(0));
        @(posedge clk); #1;
        check("abort_state", 32'(state), 32'(0));
        check("abort_retired", retired, 32'(0));
        check("abort_strobes", 32'(strobes), 32'(0));
        exp_retired = 0;
        rst = 1'b0; run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("run0_idle", 32'(state), 32'(0));
        run = 1'b1;
        @(posedge clk); #1;
        check("run1_fetch", 32'(state), 32'(1));

        // Fetch timeout: mem_ready held low
        for (int i = 0; i < int'(TMO); i++) begin
            check("tmo_fetch_state", 32'(state), 32'(1));
            check("tmo_no_error", 32'(error), 32'(0));
            @(posedge clk); #1;
        end
        check("tmo_err_state", 32'(state), 32'(6));
        check("tmo_error", 32'(error), 32'(1));
        check("tmo_strobes", 32'(strobes), 32'(0));
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky_state", 32'(state), 32'(6));
        check("err_sticky", 32'(error), 32'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("err_cleared", 32'(error), 32'(0));
        check("err_reset_state", 32'(state), 32'(0));
        rst = 1'b0;
        check("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
